// File: rtl/regfile_sync_clr.sv
// Parametrised single-write, dual-read register file with registered read ports,
// write-through bypass, an optional hard-zero register and a hardware clear sequencer.
module regfile_sync_clr #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int HAS_ZERO = 1,
    parameter int ZERO_IDX = 31
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ClearReq,
    input  logic              RegWr,
    input  logic [ADDR_W-1:0] RW,
    input  logic [WIDTH-1:0]  BusW,
    input  logic              ReA,
    input  logic [ADDR_W-1:0] RA,
    input  logic              ReB,
    input  logic [ADDR_W-1:0] RB,
    output logic [WIDTH-1:0]  BusA,
    output logic [WIDTH-1:0]  BusB,
    output logic              Busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] bus_a_q, bus_a_d;
    logic [WIDTH-1:0] bus_b_q, bus_b_d;
    logic [WIDTH-1:0] regs_q [DEPTH];

    logic             wr_legal_s;
    logic             mem_we_s;
    logic [IDX_W-1:0] mem_addr_s;
    logic [WIDTH-1:0] mem_data_s;

    // An address is writable/readable only if it maps to a real, non-hard-zero entry.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        logic in_range;
        logic is_zero;
        in_range = (32'(a) < 32'(DEPTH));
        is_zero  = (HAS_ZERO != 0) && (32'(a) == 32'(ZERO_IDX));
        return in_range && !is_zero;
    endfunction

    // Read value resolution, including bypass of a same-cycle legal write.
    function automatic logic [WIDTH-1:0] read_value(input logic [ADDR_W-1:0] a);
        logic [WIDTH-1:0] v;
        if (state_q == CLEAR) begin
            v = {WIDTH{1'b0}};
        end else if (!addr_ok(a)) begin
            v = {WIDTH{1'b0}};
        end else if (wr_legal_s && (RW == a)) begin
            v = BusW;
        end else begin
            v = regs_q[a[IDX_W-1:0]];
        end
        return v;
    endfunction

    // Qualify the external write request.
    always_comb begin
        wr_legal_s = RegWr && (state_q == IDLE) && addr_ok(RW);
    end

    // Sequencer next state and the single array write port.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mem_we_s   = 1'b0;
        mem_addr_s = idx_q;
        mem_data_s = {WIDTH{1'b0}};
        case (state_q)
            IDLE: begin
                if (wr_legal_s) begin
                    mem_we_s   = 1'b1;
                    mem_addr_s = RW[IDX_W-1:0];
                    mem_data_s = BusW;
                end else begin
                    mem_we_s   = 1'b0;
                end
                if (ClearReq) begin
                    state_d = CLEAR;
                    idx_d   = {IDX_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                mem_we_s   = 1'b1;
                mem_addr_s = idx_q;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = {IDX_W{1'b0}};
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = CLEAR;
                idx_d   = {IDX_W{1'b0}};
            end
        endcase
        busy_d = (state_d == CLEAR);
    end

    // Registered read ports hold their value when not enabled.
    always_comb begin
        if (ReA) begin
            bus_a_d = read_value(RA);
        end else begin
            bus_a_d = bus_a_q;
        end
        if (ReB) begin
            bus_b_d = read_value(RB);
        end else begin
            bus_b_d = bus_b_q;
        end
    end

    // Control and output registers; reset forces a fresh clear sequence.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= CLEAR;
            idx_q   <= {IDX_W{1'b0}};
            busy_q  <= 1'b1;
            bus_a_q <= {WIDTH{1'b0}};
            bus_b_q <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            bus_a_q <= bus_a_d;
            bus_b_q <= bus_b_d;
        end
    end

    // Storage array is never reset; the clear sequence zeroes it.
    always_ff @(posedge Clk) begin
        if (mem_we_s) begin
            regs_q[mem_addr_s] <= mem_data_s;
        end
    end

    assign BusA = bus_a_q;
    assign BusB = bus_b_q;
    assign Busy = busy_q;

endmodule

// File: tb/tb_regfile_sync_clr.sv
// Directed testbench for regfile_sync_clr: default build, a HAS_ZERO=0 build and
// a narrow/shallow build share one stimulus stream.
module tb_regfile_sync_clr;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear_req = 1'b0;
    logic        reg_wr = 1'b0;
    logic        re_a = 1'b0;
    logic        re_b = 1'b0;
    logic [4:0]  rw = 5'd0;
    logic [4:0]  ra = 5'd0;
    logic [4:0]  rb = 5'd0;
    logic [63:0] bus_w = 64'd0;

    logic [63:0] a0, b0, a1, b1;
    logic [31:0] a2, b2;
    logic        busy0, busy1, busy2;

    int checks = 0;
    int failures = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] DEAD = 64'hDEAD_BEEF_0000_0001;

    always #5 clk = ~clk;

    regfile_sync_clr u0 (
        .Clk(clk), .Reset(rst), .ClearReq(clear_req), .RegWr(reg_wr), .RW(rw), .BusW(bus_w),
        .ReA(re_a), .RA(ra), .ReB(re_b), .RB(rb), .BusA(a0), .BusB(b0), .Busy(busy0)
    );

    regfile_sync_clr #(.HAS_ZERO(0)) u1 (
        .Clk(clk), .Reset(rst), .ClearReq(clear_req), .RegWr(reg_wr), .RW(rw), .BusW(bus_w),
        .ReA(re_a), .RA(ra), .ReB(re_b), .RB(rb), .BusA(a1), .BusB(b1), .Busy(busy1)
    );

    regfile_sync_clr #(.WIDTH(32), .DEPTH(16), .ADDR_W(5), .HAS_ZERO(1), .ZERO_IDX(0)) u2 (
        .Clk(clk), .Reset(rst), .ClearReq(clear_req), .RegWr(reg_wr), .RW(rw), .BusW(bus_w[31:0]),
        .ReA(re_a), .RA(ra), .ReB(re_b), .RB(rb), .BusA(a2), .BusB(b2), .Busy(busy2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int cnt;
        int c2;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (a0 !== 64'd0 || b0 !== 64'd0) begin
            failures++;
            $display("FAIL reset_bus: BusA=%h BusB=%h required 0", a0, b0);
        end
        checks++;
        if (busy0 !== 1'b1 || busy2 !== 1'b1) begin
            failures++;
            $display("FAIL reset_busy: busy0=%b busy2=%b required 1", busy0, busy2);
        end
        repeat (2) tick;
        rst = 1'b0;
        cnt = 0;
        c2 = 0;
        while (busy0 && cnt < 100) begin
            tick;
            cnt++;
            if (!busy2 && c2 == 0) c2 = cnt;
        end
        checks++;
        if (cnt != 32) begin
            failures++;
            $display("FAIL reset_busy_len: got %0d cycles required 32", cnt);
        end
        checks++;
        if (c2 != 16) begin
            failures++;
            $display("FAIL reset_busy_len_small: got %0d cycles required 16", c2);
        end
        for (int i = 0; i < 32; i++) begin
            re_a = 1'b1;
            ra = 5'(i);
            tick;
            checks++;
            if (a0 !== 64'd0 || a1 !== 64'd0) begin
                failures++;
                $display("FAIL reset_read_zero[%0d]: a0=%h a1=%h required 0", i, a0, a1);
            end
        end
        re_a = 1'b0;
    endtask

    task automatic test_bypass;
        reg_wr = 1'b1; rw = 5'd5; bus_w = DEAD; re_a = 1'b1; ra = 5'd5;
        tick;
        checks++;
        if (a0 !== DEAD) begin
            failures++;
            $display("FAIL bypass: BusA=%h required %h", a0, DEAD);
        end
        reg_wr = 1'b0; bus_w = 64'd0;
        tick;
        checks++;
        if (a0 !== DEAD) begin
            failures++;
            $display("FAIL array_read: BusA=%h required %h", a0, DEAD);
        end
        re_a = 1'b0; ra = 5'd0;
        tick;
        checks++;
        if (a0 !== DEAD) begin
            failures++;
            $display("FAIL read_hold: BusA=%h required %h", a0, DEAD);
        end
    endtask

    task automatic test_zero;
        reg_wr = 1'b1; rw = 5'd31; bus_w = ONES;
        re_a = 1'b1; ra = 5'd31; re_b = 1'b1; rb = 5'd31;
        tick;
        checks++;
        if (a0 !== 64'd0 || a1 !== ONES) begin
            failures++;
            $display("FAIL zero_bypass: a0=%h required 0, a1=%h required %h", a0, a1, ONES);
        end
        reg_wr = 1'b0; bus_w = 64'd0;
        tick;
        checks++;
        if (a0 !== 64'd0 || b0 !== 64'd0) begin
            failures++;
            $display("FAIL zero_reg: a0=%h b0=%h required 0", a0, b0);
        end
        checks++;
        if (a1 !== ONES || b1 !== ONES) begin
            failures++;
            $display("FAIL nozero_reg: a1=%h b1=%h required %h", a1, b1, ONES);
        end
        checks++;
        if (a2 !== 32'd0) begin
            failures++;
            $display("FAIL small_out_of_range31: a2=%h required 0", a2);
        end
        re_a = 1'b0; re_b = 1'b0;
    endtask

    task automatic test_params;
        reg_wr = 1'b1; rw = 5'd20; bus_w = 64'd7;
        tick;
        reg_wr = 1'b0; re_a = 1'b1; ra = 5'd20;
        tick;
        checks++;
        if (a2 !== 32'd0 || a0 !== 64'd7) begin
            failures++;
            $display("FAIL param_range: a2=%h required 0, a0=%h required 7", a2, a0);
        end
        reg_wr = 1'b1; rw = 5'd15; bus_w = 64'h1234; re_a = 1'b0;
        tick;
        reg_wr = 1'b0; re_a = 1'b1; ra = 5'd15;
        tick;
        checks++;
        if (a2 !== 32'h1234) begin
            failures++;
            $display("FAIL param_last_entry: a2=%h required 1234", a2);
        end
        reg_wr = 1'b1; rw = 5'd0; bus_w = 64'h55; re_a = 1'b0;
        tick;
        reg_wr = 1'b0; re_a = 1'b1; ra = 5'd0;
        tick;
        checks++;
        if (a2 !== 32'd0 || a0 !== 64'h55) begin
            failures++;
            $display("FAIL param_zero_idx: a2=%h required 0, a0=%h required 55", a2, a0);
        end
        re_a = 1'b0;
    endtask

    task automatic test_clear;
        int cnt;
        for (int i = 1; i <= 4; i++) begin
            reg_wr = 1'b1; rw = 5'(i); bus_w = 64'(i);
            tick;
        end
        clear_req = 1'b1; reg_wr = 1'b1; rw = 5'd4; bus_w = 64'd44; re_a = 1'b1; ra = 5'd4;
        tick;
        checks++;
        if (a0 !== 64'd44 || busy0 !== 1'b1) begin
            failures++;
            $display("FAIL clear_start: a0=%h required 2c, busy=%b required 1", a0, busy0);
        end
        clear_req = 1'b0; reg_wr = 1'b0; re_a = 1'b0;
        cnt = 0;
        while (busy0 && cnt < 100) begin
            re_b = 1'b1;
            rb = 5'(1 + cnt % 4);
            reg_wr = (cnt == 2) || (cnt == 20);
            rw = 5'd2;
            bus_w = 64'd9;
            clear_req = (cnt == 5);
            tick;
            cnt++;
            checks++;
            if (b0 !== 64'd0) begin
                failures++;
                $display("FAIL clear_busb[%0d]: BusB=%h required 0", cnt, b0);
            end
        end
        reg_wr = 1'b0; clear_req = 1'b0;
        checks++;
        if (cnt != 32) begin
            failures++;
            $display("FAIL clear_busy_len: got %0d cycles required 32", cnt);
        end
        checks++;
        if (a0 !== 64'd44) begin
            failures++;
            $display("FAIL clear_hold_a: BusA=%h required 2c", a0);
        end
        for (int i = 1; i <= 4; i++) begin
            re_a = 1'b1; ra = 5'(i); re_b = 1'b1; rb = 5'(i);
            tick;
            checks++;
            if (a0 !== 64'd0 || b0 !== 64'd0) begin
                failures++;
                $display("FAIL clear_result[%0d]: a0=%h b0=%h required 0", i, a0, b0);
            end
        end
        re_a = 1'b0; re_b = 1'b0;
    endtask

    task automatic test_reset_mid_clear;
        int cnt;
        int c2;
        reg_wr = 1'b1; rw = 5'd3; bus_w = 64'h33;
        tick;
        reg_wr = 1'b0; re_a = 1'b1; ra = 5'd3; re_b = 1'b1; rb = 5'd3;
        tick;
        re_a = 1'b0; re_b = 1'b0;
        checks++;
        if (a0 !== 64'h33 || b0 !== 64'h33) begin
            failures++;
            $display("FAIL mid_preload: a0=%h b0=%h required 33", a0, b0);
        end
        clear_req = 1'b1;
        tick;
        clear_req = 1'b0;
        repeat (10) tick;
        checks++;
        if (busy0 !== 1'b1 || a0 !== 64'h33) begin
            failures++;
            $display("FAIL mid_before_reset: busy=%b required 1, a0=%h required 33", busy0, a0);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (a0 !== 64'd0 || b0 !== 64'd0 || busy0 !== 1'b1) begin
            failures++;
            $display("FAIL mid_async_reset: a0=%h b0=%h required 0, busy=%b required 1", a0, b0, busy0);
        end
        tick;
        rst = 1'b0;
        cnt = 0;
        c2 = 0;
        while (busy0 && cnt < 100) begin
            tick;
            cnt++;
            if (!busy2 && c2 == 0) c2 = cnt;
        end
        checks++;
        if (cnt != 32 || c2 != 16) begin
            failures++;
            $display("FAIL mid_restart_len: got %0d/%0d cycles required 32/16", cnt, c2);
        end
    endtask

    initial begin
        test_reset;
        test_bypass;
        test_zero;
        test_params;
        test_clear;
        test_reset_mid_clear;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
